// File: rtl/ahb_icache_assoc.sv
// ahb_icache_assoc
// N-way set-associative, read-only instruction cache between a CPU fetch port
// (AHB-Lite slave) and the memory bus (AHB-Lite master).
//
// Ports:
//   hclk, hrst            clock, synchronous active-high reset
//   s_*                   CPU-side AHB-Lite slave (reads only; writes get ERROR)
//   m_*                   memory-side AHB-Lite master (WRAP4/WRAP8 line refill)
//   flush                 invalidate every line and reset replacement pointers
//   hit_count, miss_count saturating lookup counters
//
// Lookup reads tags and data combinationally from the address phase, so a hit
// returns data in the very next cycle.  A miss refills the whole line with a
// wrapping burst that starts at the requested word; each beat is written
// straight into the victim way, which stays invalid until the last beat lands.
module ahb_icache_assoc #(
    parameter int CACHE_SIZE = 8192,
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2
) (
    input  logic        hclk,
    input  logic        hrst,
    input  logic        s_hsel,
    input  logic        s_hwrite,
    input  logic        s_hready,
    input  logic [31:0] s_haddr,
    input  logic [1:0]  s_htrans,
    input  logic [2:0]  s_hburst,
    output logic        s_hreadyout,
    output logic [31:0] s_hrdata,
    output logic        s_hresp,
    output logic [31:0] m_haddr,
    output logic [1:0]  m_htrans,
    output logic [2:0]  m_hburst,
    output logic        m_hwrite,
    output logic [2:0]  m_hsize,
    input  logic [31:0] m_hrdata,
    input  logic        m_hready,
    input  logic        m_hresp,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int SETS     = CACHE_SIZE / (4 * LINE_WORDS * WAYS);
    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = 30 - INDEX_W - OFFSET_W;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] WRAP_BURST = (LINE_WORDS == 8) ? 3'b100 : 3'b010;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RESP, S_ERR1, S_ERR2} state_t;

    state_t state;

    // Storage
    logic [31:0]           data_mem [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0]      tag_mem  [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0]  valid;
    logic [SETS-1:0][WAY_W-1:0] rr_ptr;
    logic                  flush_pend;

    // Refill bookkeeping
    logic [TAG_W-1:0]    f_tag;
    logic [INDEX_W-1:0]  f_idx;
    logic [WAY_W-1:0]    f_way;
    logic [OFFSET_W-1:0] f_crit;
    logic                f_full;
    logic [OFFSET_W-1:0] a_cnt;    // address beats issued
    logic [OFFSET_W-1:0] a_off;    // offset of the beat currently on m_haddr
    logic [OFFSET_W-1:0] d_cnt;    // data beats received
    logic                d_pend;   // a data phase is outstanding

    // Address phase decode
    logic [OFFSET_W-1:0] c_off;
    logic [INDEX_W-1:0]  c_idx;
    logic [TAG_W-1:0]    c_tag;
    assign c_off = s_haddr[OFFSET_W+1:2];
    assign c_idx = s_haddr[OFFSET_W+2 +: INDEX_W];
    assign c_tag = s_haddr[31 -: TAG_W];

    logic accepting, xfer, rd_acc, wr_acc;
    assign accepting = (state == S_IDLE) || (state == S_RESP) || (state == S_ERR2);
    assign xfer      = s_hsel && s_hready && s_htrans[1];
    assign rd_acc    = accepting && xfer && !s_hwrite;
    assign wr_acc    = accepting && xfer && s_hwrite;

    // Tag compare and victim choice; descending loop leaves the lowest index
    // winning for both the hit way and the first invalid way.
    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [WAY_W-1:0] hit_way, victim;
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        victim  = rr_ptr[c_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid[c_idx][w] && (tag_mem[c_idx][w] == c_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid[c_idx][w]) victim = WAY_W'(w);
        end
    end
    assign hit = |hit_vec;

    logic beat_wr, fill_done;
    logic [OFFSET_W-1:0] d_word, next_off;
    assign beat_wr   = (state == S_FILL) && d_pend && m_hready && !m_hresp;
    assign fill_done = beat_wr && (d_cnt == LAST_WORD);
    assign d_word    = f_crit + d_cnt;
    assign next_off  = a_off + 1'b1;

    assign m_hwrite = 1'b0;
    assign m_hsize  = 3'b010;

    logic unused_ok;
    assign unused_ok = ^{s_hburst, s_haddr[1:0], s_htrans[0]};

    // Arrays without reset: valid bits guard every read.
    always_ff @(posedge hclk) begin
        if (beat_wr)   data_mem[f_way][f_idx][d_word] <= m_hrdata;
        if (fill_done) tag_mem[f_idx][f_way] <= f_tag;
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state       <= S_IDLE;
            s_hreadyout <= 1'b1;
            s_hresp     <= 1'b0;
            s_hrdata    <= '0;
            m_haddr     <= '0;
            m_htrans    <= HT_IDLE;
            m_hburst    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            valid       <= '0;
            rr_ptr      <= '0;
            flush_pend  <= 1'b0;
            f_tag       <= '0;
            f_idx       <= '0;
            f_way       <= '0;
            f_crit      <= '0;
            f_full      <= 1'b0;
            a_cnt       <= '0;
            a_off       <= '0;
            d_cnt       <= '0;
            d_pend      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_RESP, S_ERR2: begin
                    state       <= S_IDLE;
                    s_hreadyout <= 1'b1;
                    s_hresp     <= 1'b0;
                    // The lookup below used the pre-flush valids, so a flush
                    // coincident with a lookup takes effect after it.
                    if (flush || flush_pend) begin
                        valid      <= '0;
                        rr_ptr     <= '0;
                        flush_pend <= 1'b0;
                    end
                    if (wr_acc) begin
                        state       <= S_ERR1;
                        s_hreadyout <= 1'b0;
                        s_hresp     <= 1'b1;
                    end else if (rd_acc) begin
                        if (hit) begin
                            if (hit_count != '1) hit_count <= hit_count + 32'd1;
                            s_hrdata <= data_mem[hit_way][c_idx][c_off];
                        end else begin
                            if (miss_count != '1) miss_count <= miss_count + 32'd1;
                            state       <= S_FILL;
                            s_hreadyout <= 1'b0;
                            f_tag       <= c_tag;
                            f_idx       <= c_idx;
                            f_way       <= victim;
                            f_crit      <= c_off;
                            f_full      <= &valid[c_idx];
                            valid[c_idx][victim] <= 1'b0;
                            m_htrans    <= HT_NONSEQ;
                            m_haddr     <= {c_tag, c_idx, c_off, 2'b00};
                            m_hburst    <= WRAP_BURST;
                            a_cnt       <= '0;
                            a_off       <= c_off;
                            d_cnt       <= '0;
                            d_pend      <= 1'b0;
                        end
                    end
                end

                S_FILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (d_pend && m_hresp) begin
                        // Abort on the first error cycle; victim stays invalid.
                        m_htrans    <= HT_IDLE;
                        d_pend      <= 1'b0;
                        state       <= S_ERR1;
                        s_hresp     <= 1'b1;
                        s_hreadyout <= 1'b0;
                    end else if (m_hready) begin
                        if (d_pend) begin
                            d_cnt <= d_cnt + 1'b1;
                            if (d_cnt == '0) s_hrdata <= m_hrdata;
                        end
                        if (m_htrans[1]) begin
                            d_pend <= 1'b1;
                            a_cnt  <= a_cnt + 1'b1;
                            if (a_cnt == LAST_WORD) begin
                                m_htrans <= HT_IDLE;
                            end else begin
                                m_htrans <= HT_SEQ;
                                a_off    <= next_off;
                                m_haddr  <= {f_tag, f_idx, next_off, 2'b00};
                            end
                        end else begin
                            d_pend <= 1'b0;
                        end
                        if (fill_done) begin
                            state       <= S_RESP;
                            s_hreadyout <= 1'b1;
                            s_hresp     <= 1'b0;
                            d_pend      <= 1'b0;
                            valid[f_idx][f_way] <= 1'b1;
                            if (f_full)
                                rr_ptr[f_idx] <= (rr_ptr[f_idx] == WAY_W'(WAYS - 1)) ?
                                                 '0 : rr_ptr[f_idx] + 1'b1;
                        end
                    end
                end

                S_ERR1: begin
                    state       <= S_ERR2;
                    s_hreadyout <= 1'b1;
                    s_hresp     <= 1'b1;
                    if (flush) begin
                        valid  <= '0;
                        rr_ptr <= '0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
